seq_pattern_tx: RTL and testbench

Serial pattern transmitter for the "00 or 11" Mealy detector path. It accepts a parallel word and shifts it out MSB-first as the serial stream `w`. Alongside each bit it produces `z_exp`, the expected detector output for that bit, so the word can drive the detector and be self-checked in the same lab bench. At end of frame it reports how many matches the frame contained.

---
 rtl/seq_pattern_tx_if.sv | 26 ++
 rtl/seq_pattern_tx.sv | 73 +++++++
 tb/tb_seq_pattern_tx.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_tx_if.sv
// Handshake and serial bus for seq_pattern_tx.
// master drives load/din; slave returns ready, w, w_valid, z_exp, done, match_cnt.
interface seq_pattern_tx_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH);

  logic             load;
  logic [WIDTH-1:0] din;
  logic             ready;
  logic             w;
  logic             w_valid;
  logic             z_exp;
  logic             done;
  logic [CW-1:0]    match_cnt;

  modport master (
    output load, din,
    input  ready, w, w_valid, z_exp, done, match_cnt
  );

  modport slave (
    input  load, din,
    output ready, w, w_valid, z_exp, done, match_cnt
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial "00 or 11" pattern transmitter with expected-detector output.
// Ports: clk, reset (async active-low), bus (load/din in; ready/w/w_valid/z_exp/done/match_cnt out).
module seq_pattern_tx #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  seq_pattern_tx_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             prev;
  logic             hv;
  logic [CW-1:0]    mc;

  logic in_shift;
  logic bit_now;
  logic z;

  assign in_shift = (state == SHIFT);
  assign bit_now  = sr[WIDTH-1];
  // hv is clear on the first bit so history never spans frames
  assign z        = in_shift & hv & (bit_now == prev);

  assign bus.ready     = (state == IDLE);
  assign bus.w         = in_shift & bit_now;
  assign bus.w_valid   = in_shift;
  assign bus.z_exp     = z;
  assign bus.done      = (state == DONE);
  assign bus.match_cnt = mc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      prev  <= 1'b0;
      hv    <= 1'b0;
      mc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            sr    <= bus.din;
            cnt   <= CW'(WIDTH - 1);
            hv    <= 1'b0;
            mc    <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          prev <= bit_now;
          hv   <= 1'b1;
          sr   <= sr << 1;
          mc   <= mc + CW'(z);
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - CW'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: WIDTH=8 and WIDTH=2 instances.
// Stimulus pushes expected bits/counts; negedge monitors pop and compare.
module tb_seq_pattern_tx;
  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  seq_pattern_tx_if #(.WIDTH(8)) b8 ();
  seq_pattern_tx_if #(.WIDTH(2)) b2 ();

  seq_pattern_tx #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (b8)
  );

  seq_pattern_tx #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2)
  );

  int n_pass = 0;
  int n_total = 0;
  bit sb_on = 1'b1;

  logic qw8[$];
  logic qz8[$];
  int   qc8[$];
  logic qw2[$];
  logic qz2[$];
  int   qc2[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
  endtask

  task automatic miss(input string nm);
    n_total++;
    $display("FAIL %s actual=unexpected required=none t=%0t", nm, $time);
  endtask

  always @(negedge clk) begin
    if (reset && sb_on) begin
      if (b8.w_valid) begin
        if (qw8.size() == 0) miss("w8_extra");
        else begin
          chk("w8", int'(b8.w), int'(qw8.pop_front()));
          chk("z8", int'(b8.z_exp), int'(qz8.pop_front()));
        end
      end else begin
        chk("idle_wz8", int'({b8.w, b8.z_exp}), 0);
      end
      if (b8.done) begin
        if (qc8.size() == 0) miss("done8_extra");
        else begin
          chk("cnt8", int'(b8.match_cnt), qc8.pop_front());
          chk("done_rdy8", int'(b8.ready), 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset && sb_on) begin
      if (b2.w_valid) begin
        if (qw2.size() == 0) miss("w2_extra");
        else begin
          chk("w2", int'(b2.w), int'(qw2.pop_front()));
          chk("z2", int'(b2.z_exp), int'(qz2.pop_front()));
        end
      end else begin
        chk("idle_wz2", int'({b2.w, b2.z_exp}), 0);
      end
      if (b2.done) begin
        if (qc2.size() == 0) miss("done2_extra");
        else chk("cnt2", int'(b2.match_cnt), qc2.pop_front());
      end
    end
  end

  task automatic wait_rdy8();
    int t = 0;
    while (!b8.ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!b8.ready) miss("rdy8_timeout");
  endtask

  task automatic wait_rdy2();
    int t = 0;
    while (!b2.ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!b2.ready) miss("rdy2_timeout");
  endtask

  task automatic push8(input logic [7:0] d, input logic [7:0] zv, input int c);
    for (int i = 7; i >= 0; i--) begin
      qw8.push_back(d[i]);
      qz8.push_back(zv[i]);
    end
    qc8.push_back(c);
  endtask

  task automatic send8(input logic [7:0] d, input logic [7:0] zv, input int c);
    wait_rdy8();
    push8(d, zv, c);
    b8.din  = d;
    b8.load = 1'b1;
    @(posedge clk); #1;
    b8.load = 1'b0;
    b8.din  = ~d;
  endtask

  task automatic send2(input logic [1:0] d, input logic [1:0] zv, input int c);
    wait_rdy2();
    for (int i = 1; i >= 0; i--) begin
      qw2.push_back(d[i]);
      qz2.push_back(zv[i]);
    end
    qc2.push_back(c);
    b2.din  = d;
    b2.load = 1'b1;
    @(posedge clk); #1;
    b2.load = 1'b0;
    b2.din  = ~d;
  endtask

  task automatic drain();
    int t = 0;
    while ((qw8.size() + qc8.size() + qw2.size() + qc2.size()) != 0
           && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if ((qw8.size() + qc8.size() + qw2.size() + qc2.size()) != 0)
      miss("drain_timeout");
  endtask

  task automatic rst_outs8(input string nm);
    chk({nm, "_ready"}, int'(b8.ready), 1);
    chk({nm, "_w"}, int'(b8.w), 0);
    chk({nm, "_wv"}, int'(b8.w_valid), 0);
    chk({nm, "_z"}, int'(b8.z_exp), 0);
    chk({nm, "_done"}, int'(b8.done), 0);
    chk({nm, "_cnt"}, int'(b8.match_cnt), 0);
  endtask

  initial begin
    b8.load = 1'b0;
    b8.din  = '0;
    b2.load = 1'b0;
    b2.din  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_outs8("por");
    chk("por2_ready", int'(b2.ready), 1);
    chk("por2_cnt", int'(b2.match_cnt), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // frame F0 interrupted by reset mid-shift
    sb_on = 1'b0;
    b8.din  = 8'hF0;
    b8.load = 1'b1;
    @(posedge clk); #1;
    b8.load = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_wv_before", int'(b8.w_valid), 1);
    reset = 1'b0;
    #1;
    rst_outs8("arst");
    @(posedge clk); #1;
    reset = 1'b1;
    sb_on = 1'b1;

    send8(8'b0011_0101, 8'b0101_0000, 2);
    send8(8'hFF, 8'b0111_1111, 7);
    send8(8'h00, 8'b0111_1111, 7);
    send8(8'hAA, 8'b0000_0000, 0);
    send8(8'h01, 8'b0111_1110, 6);
    send8(8'h80, 8'b0011_1111, 6);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("cnt8_held", int'(b8.match_cnt), 6);

    // load held high, din changing each cycle
    wait_rdy8();
    push8(8'hC3, 8'b0101_1101, 5);
    push8(8'h5A, 8'b0000_1000, 1);
    push8(8'h0F, 8'b0111_0111, 6);
    for (int j = 0; j < 30; j++) begin
      b8.load = 1'b1;
      if (j == 0)       b8.din = 8'hC3;
      else if (j == 10) b8.din = 8'h5A;
      else if (j == 20) b8.din = 8'h0F;
      else              b8.din = 8'(j * 37 + 1);
      @(posedge clk); #1;
      chk("held_ready", int'(b8.ready), (j % 10 == 9) ? 1 : 0);
    end
    b8.load = 1'b0;
    drain();

    send2(2'b11, 2'b01, 1);
    send2(2'b10, 2'b00, 0);
    drain();
    repeat (2) @(posedge clk);
    #1;
    chk("cnt2_held", int'(b2.match_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
